seq_mult_unit: RTL and testbench
================================

SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ClearA_LoadB  input  1  in IDLE: clear A and X, load B from Din.
REQ-005 SHALL have port Run  input  1  level; starts a multiply from IDLE, releases DONE when low.
REQ-006 SHALL have port Din  input  WIDTH  signed multiplicand, or B load value.
REQ-007 SHALL have port Aval  output  WIDTH  A register, upper product half.
REQ-008 SHALL have port Bval  output  WIDTH  B register, multiplier, then lower product half.
REQ-009 SHALL have port X  output  1  sign-extension bit of A.
REQ-010 SHALL have port Busy  output  1  high in START, ADD, SUB, NOP and SHIFT.
REQ-011 SHALL have port Done  output  1  high only in DONE.

Function
REQ-012 SHALL use states IDLE, START, ADD, SUB, NOP, SHIFT and DONE; M is defined as B[0].
REQ-013 IDLE: ClearA_LoadB=1 SHALL clear A and X, load B<=Din, and stay in IDLE; this has priority over Run in the same cycle.
REQ-014 IDLE: Run=1 with ClearA_LoadB=0 SHALL move to START.
REQ-015 START SHALL clear A and X, latch Din into an internal multiplicand register S, and clear the bit counter; B is kept.
REQ-016 Compute step, per bit: M=1 on bits 0..WIDTH-2 -> ADD; M=1 on bit WIDTH-1 -> SUB; M=0 -> NOP; every compute step is followed by SHIFT.
REQ-017 ADD SHALL form {X,A} <= sext(A)+sext(S) at WIDTH+1 bits.
REQ-018 SUB SHALL form {X,A} <= sext(A)-sext(S) at WIDTH+1 bits.
REQ-019 NOP SHALL leave A, B, X and S unchanged.
REQ-020 SHIFT SHALL perform an arithmetic right shift of {X,A,B}: X kept, A<={X,A[W-1:1]}, B<={A[0],B[W-1:1]}, and the counter increments.
REQ-021 SHIFT of bit WIDTH-1 SHALL go to DONE; any other SHIFT SHALL go to the next compute step.
REQ-022 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap during an operation.
REQ-023 Latency is fixed: if IDLE->START occurs on edge n, DONE SHALL be entered on edge n+1+2*WIDTH, independent of operand values.
REQ-024 DONE SHALL hold {A,B} as the 2*WIDTH-bit signed product, with X equal to A[W-1]; it SHALL stay in DONE while Run=1 and return to IDLE on the first edge with Run=0.
REQ-025 Din changes after START, and ClearA_LoadB outside IDLE, SHALL have no effect.
REQ-026 A new Run from IDLE SHALL multiply S by the current B, which is the previous product's low half.

Reset
REQ-027 Reset_n=0 SHALL immediately force IDLE, clear A, B, X, S and the counter, and drive Busy=0 and Done=0 (and Ovf=0 when present), including mid-operation.
REQ-028 Release of Reset_n SHALL take effect on the next rising edge of Clk with no spurious state change.

Configuration
REQ-029 With macro SEQ_MULT_OVF_FLAG_EN defined, the block SHALL add output Ovf (1 bit): in DONE, Ovf=1 iff A differs from WIDTH copies of B[W-1]; Ovf=0 in all other states.
REQ-030 Without SEQ_MULT_OVF_FLAG_EN, the Ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package mult_pkg SHALL hold the state enum typedef and the default-width constant MULT_WIDTH_DEF=8.
REQ-032 The WIDTH+1-bit signed adder/subtractor SHALL be sub-module add_sub_w (inputs a, b, sub; output sum); the FSM and registers stay in seq_mult_unit.

Verification
REQ-033 WIDTH=8, load B=0xC5, Run with Din=0x07 -> after 17 edges Done=1, Aval:Bval=0xFE63, X=1, Ovf=0.
REQ-034 WIDTH=8, B=0xFF, Din=0xFF -> product 0x0001, X=0; Run held 5 extra cycles keeps Done=1; Run=0 -> IDLE next edge.
REQ-035 WIDTH=8, B=0x80, Din=0x80 -> product 0x4000, Ovf=1 (macro on); Ovf port absent with macro off.
REQ-036 WIDTH=16, B=0x7FFF, Din=0x7FFF -> product 0x3FFF0001 after 33 edges; Din toggled mid-operation -> same result.
REQ-037 Reset_n pulsed low during the 5th SHIFT -> outputs zero immediately, IDLE; a subsequent load and Run give a correct product.
REQ-038 ClearA_LoadB and Run high together in IDLE -> B loaded, no START that cycle; START on the next edge if Run is still high.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth-style signed multiplier.
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADD   = 3'd2,
    ST_SUB   = 3'd3,
    ST_NOP   = 3'd4,
    ST_SHIFT = 3'd5,
    ST_DONE  = 3'd6
  } mult_state_e;

  // Compute step for one multiplier bit: the sign bit weight is negative, so it subtracts.
  function automatic mult_state_e step_state(input logic m, input logic last);
    mult_state_e st;
    if (!m) begin
      st = ST_NOP;
    end else if (last) begin
      st = ST_SUB;
    end else begin
      st = ST_ADD;
    end
    return st;
  endfunction

endpackage

// File: rtl/add_sub_w.sv
// W-bit two's-complement adder/subtractor used for the partial-product step.
module add_sub_w #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // Single shared datapath; sub selects a-b instead of a+b.
  always_comb begin
    if (sub) begin
      sum = a - b;
    end else begin
      sum = a + b;
    end
  end

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential signed multiplier: {A,B} <= S * B over 2*WIDTH+1 cycles.
// Optional Ovf output (product does not fit in WIDTH bits) enabled by SEQ_MULT_OVF_FLAG_EN.
module seq_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
`ifdef SEQ_MULT_OVF_FLAG_EN
  , output logic           Ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mult_state_e      state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic             x_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH:0]   sum_s;
  logic             sub_s;
  logic [WIDTH-1:0] shift_a_s;
  logic [WIDTH-1:0] shift_b_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             last_s;
  logic             next_last_s;

  add_sub_w #(.W(WIDTH + 1)) u_add_sub (
    .a   ({a_r[WIDTH-1], a_r}),
    .b   ({s_r[WIDTH-1], s_r}),
    .sub (sub_s),
    .sum (sum_s)
  );

  // Arithmetic right shift of {X,A,B} and bit-position bookkeeping.
  always_comb begin
    sub_s       = (state_r == ST_SUB);
    shift_a_s   = {x_r, a_r[WIDTH-1:1]};
    shift_b_s   = {a_r[0], b_r[WIDTH-1:1]};
    last_s      = (cnt_r == LAST_CNT);
    cnt_inc_s   = cnt_r + CNT_ONE;
    next_last_s = (cnt_inc_s == LAST_CNT);
  end

`ifdef SEQ_MULT_OVF_FLAG_EN
  logic ovf_r;
  logic ovf_next_s;

  // Upper half must be pure sign extension of the lower half for the product to fit.
  always_comb begin
    ovf_next_s = (shift_a_s != {WIDTH{shift_b_s[WIDTH-1]}});
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      x_r     <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SEQ_MULT_OVF_FLAG_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ClearA_LoadB) begin
            a_r <= '0;
            x_r <= 1'b0;
            b_r <= Din;
          end else if (Run) begin
            state_r <= ST_START;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          a_r     <= '0;
          x_r     <= 1'b0;
          s_r     <= Din;
          cnt_r   <= '0;
          state_r <= step_state(b_r[0], LAST_CNT == '0);
        end
        ST_ADD, ST_SUB: begin
          {x_r, a_r} <= sum_s;
          state_r    <= ST_SHIFT;
        end
        ST_NOP: begin
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          a_r <= shift_a_s;
          b_r <= shift_b_s;
          if (last_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
`ifdef SEQ_MULT_OVF_FLAG_EN
            ovf_r   <= ovf_next_s;
`endif
          end else begin
            // Counter holds at its last value so it never wraps.
            cnt_r   <= cnt_inc_s;
            state_r <= step_state(b_r[1], next_last_s);
          end
        end
        ST_DONE: begin
          if (!Run) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
`ifdef SEQ_MULT_OVF_FLAG_EN
            ovf_r   <= 1'b0;
`endif
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Aval = a_r;
  assign Bval = b_r;
  assign X    = x_r;
  assign Busy = busy_r;
  assign Done = done_r;
`ifdef SEQ_MULT_OVF_FLAG_EN
  assign Ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed self-checking bench for seq_mult_unit at WIDTH=8 and WIDTH=16.
module tb_seq_mult_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        ld8, run8;
  logic [7:0]  din8, a8, b8;
  logic        x8, busy8, done8;
  logic        ld16, run16;
  logic [15:0] din16, a16, b16;
  logic        x16, busy16, done16;
`ifdef SEQ_MULT_OVF_FLAG_EN
  logic        ovf8, ovf16;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  seq_mult_unit #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .ClearA_LoadB(ld8), .Run(run8), .Din(din8),
    .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
`ifdef SEQ_MULT_OVF_FLAG_EN
    , .Ovf(ovf8)
`endif
  );

  seq_mult_unit #(.WIDTH(16)) u_dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .ClearA_LoadB(ld16), .Run(run16), .Din(din16),
    .Aval(a16), .Bval(b16), .X(x16), .Busy(busy16), .Done(done16)
`ifdef SEQ_MULT_OVF_FLAG_EN
    , .Ovf(ovf16)
`endif
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load8(input logic [7:0] v);
    ld8  = 1'b1;
    din8 = v;
    tick();
    ld8  = 1'b0;
    chk("load_b8", 32'(b8), 32'(v));
  endtask

  // Start a multiply, scramble Din after S is latched, check latency and result; Run stays high.
  task automatic mul8(input string tag, input logic [7:0] s, input logic [15:0] exp_p, input logic exp_x);
    din8 = s;
    run8 = 1'b1;
    tick();
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    tick();
    din8 = ~s;
    repeat (15) tick();
    chk({tag, "_early_done"}, 32'(done8), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy8), 32'd0);
    chk({tag, "_prod"}, 32'({a8, b8}), 32'(exp_p));
    chk({tag, "_x"}, 32'(x8), 32'(exp_x));
  endtask

  task automatic release8(input string tag);
    run8 = 1'b0;
    tick();
    chk({tag, "_idle_done"}, 32'(done8), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy8), 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    ld8 = 1'b0; run8 = 1'b0; din8 = 8'h00;
    ld16 = 1'b0; run16 = 1'b0; din16 = 16'h0000;
    tick();
    tick();
    chk("rst_a", 32'(a8), 32'd0);
    chk("rst_b", 32'(b8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    Reset_n = 1'b1;
    tick();
    chk("rel_busy", 32'(busy8), 32'd0);
    chk("rel_b", 32'(b8), 32'd0);

    // -59 * 7 = -413
    load8(8'hC5);
    mul8("m1", 8'h07, 16'hFE63, 1'b1);
    release8("m1");

    // -1 * -1 = 1, with Run held in DONE
    load8(8'hFF);
    mul8("m2", 8'hFF, 16'h0001, 1'b0);
`ifdef SEQ_MULT_OVF_FLAG_EN
    chk("m2_ovf", 32'(ovf8), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("m2_hold_done", 32'(done8), 32'd1);
    end
    release8("m2");

    // Chained: B now holds 0x01 from the previous low half; 1 * -123 = -123
    mul8("m_chain", 8'h85, 16'hFF85, 1'b1);
`ifdef SEQ_MULT_OVF_FLAG_EN
    chk("m_chain_ovf", 32'(ovf8), 32'd0);
`endif
    release8("m_chain");

    // -128 * -128 = 16384
    load8(8'h80);
    mul8("m3", 8'h80, 16'h4000, 1'b0);
`ifdef SEQ_MULT_OVF_FLAG_EN
    chk("m3_ovf", 32'(ovf8), 32'd1);
`endif
    release8("m3");

    // Load has priority over Run in IDLE; ClearA_LoadB ignored while busy: 3 * -3 = -9
    ld8 = 1'b1; run8 = 1'b1; din8 = 8'h03;
    tick();
    chk("prio_busy", 32'(busy8), 32'd0);
    chk("prio_b", 32'(b8), 32'd3);
    ld8 = 1'b0; din8 = 8'hFD;
    tick();
    chk("prio_start", 32'(busy8), 32'd1);
    tick();
    ld8 = 1'b1; din8 = 8'h55;
    repeat (15) tick();
    chk("prio_early_done", 32'(done8), 32'd0);
    tick();
    chk("prio_done", 32'(done8), 32'd1);
    chk("prio_prod", 32'({a8, b8}), 32'h0000FFF7);
    ld8 = 1'b0;
    release8("prio");

    // Reset asserted during the 5th SHIFT
    load8(8'h5A);
    din8 = 8'h11; run8 = 1'b1;
    tick();
    tick();
    repeat (9) tick();
    chk("mid_busy", 32'(busy8), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_a", 32'(a8), 32'd0);
    chk("mid_rst_b", 32'(b8), 32'd0);
    chk("mid_rst_x", 32'(x8), 32'd0);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    run8 = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy8), 32'd0);
    load8(8'h5A);
    mul8("m_post", 8'h11, 16'h05FA, 1'b0);
    release8("m_post");

    // WIDTH=16: 32767 * 32767, Din toggled mid-operation
    ld16 = 1'b1; din16 = 16'h7FFF;
    tick();
    ld16 = 1'b0; run16 = 1'b1;
    tick();
    chk("w16_busy", 32'(busy16), 32'd1);
    tick();
    din16 = 16'h1234;
    repeat (31) tick();
    chk("w16_early_done", 32'(done16), 32'd0);
    tick();
    chk("w16_done", 32'(done16), 32'd1);
    chk("w16_prod", {a16, b16}, 32'h3FFF0001);
    chk("w16_x", 32'(x16), 32'd0);
    run16 = 1'b0;
    tick();
    chk("w16_idle", 32'(done16), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
